// File: rtl/core_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// core_ctrl_fsm
//   Multi-cycle control sequencer for an RV32I core. It steps each instruction
//   through FETCH -> DECODE -> EXEC -> (MEM) -> (WB). It classifies the latched
//   opcode into an immediate format for the immediate encoder. It drives every
//   datapath select, enable and memory handshake. It traps on illegal opcodes
//   and on data-bus timeouts. An instruction-fetch timeout raises bus_err and
//   then retries the fetch.
//
// Parameters
//   TO_W         width of the bus-timeout counter
//   MEM_TIMEOUT  wait cycles before bus_err (1 .. 2**TO_W-1)
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   instr         fetched instruction word (sampled when imem_valid)
//   imem_valid    instruction response valid
//   dmem_ready    data access complete
//   branch_taken  branch comparator result (used in EXEC)
//   fetch_req     instruction fetch request
//   ir_we         instruction register load enable
//   instr_type    immediate format: 0 I, 1 S, 2 B, 3 U, 4 J, 7 none
//   alu_src_a     0 rs1, 1 pc, 2 zero
//   alu_src_b     0 rs2, 1 imm
//   alu_op        0 add, 1 funct-decoded, 2 compare
//   dmem_req      data access request
//   dmem_we       data access is a store
//   rf_we         register-file write enable
//   wb_sel        0 alu, 1 mem, 2 pc+4
//   pc_we         PC update enable
//   pc_src        0 pc+4, 1 alu target, 2 trap vector
//   illegal       one-cycle pulse: unsupported opcode
//   bus_err       one-cycle pulse: imem/dmem timeout
//   state         current state (debug)
// -----------------------------------------------------------------------------
module core_ctrl_fsm #(
    parameter int TO_W        = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        imem_valid,
    input  logic        dmem_ready,
    input  logic        branch_taken,
    output logic        fetch_req,
    output logic        ir_we,
    output logic [2:0]  instr_type,
    output logic [1:0]  alu_src_a,
    output logic        alu_src_b,
    output logic [1:0]  alu_op,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        illegal,
    output logic        bus_err,
    output logic [2:0]  state
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [TO_W-1:0] TIMEOUT_VAL = TO_W'(MEM_TIMEOUT);

    logic [2:0]      state_q, state_d;
    logic [6:0]      opcode_q, opcode_d;
    logic [TO_W-1:0] cnt_q, cnt_d;

    // Only the opcode field of the instruction word is used by the sequencer.
    logic unused_instr_hi;
    assign unused_instr_hi = ^instr[31:7];

    // ------------------------------------------------------------------
    // Opcode classification (from the latched opcode)
    // ------------------------------------------------------------------
    logic       is_load, is_store, is_branch, is_op, is_opimm;
    logic       is_jal, is_jalr, is_lui, is_auipc;
    logic       dec_legal;
    logic [2:0] dec_type;

    always_comb begin
        is_load   = (opcode_q == OPC_LOAD);
        is_store  = (opcode_q == OPC_STORE);
        is_branch = (opcode_q == OPC_BRANCH);
        is_op     = (opcode_q == OPC_OP);
        is_opimm  = (opcode_q == OPC_OPIMM);
        is_jal    = (opcode_q == OPC_JAL);
        is_jalr   = (opcode_q == OPC_JALR);
        is_lui    = (opcode_q == OPC_LUI);
        is_auipc  = (opcode_q == OPC_AUIPC);
        dec_legal = is_load | is_store | is_branch | is_op | is_opimm |
                    is_jal | is_jalr | is_lui | is_auipc;

        dec_type = 3'd7;
        if (is_load || is_opimm || is_jalr) dec_type = 3'd0;
        else if (is_store)                  dec_type = 3'd1;
        else if (is_branch)                 dec_type = 3'd2;
        else if (is_lui || is_auipc)        dec_type = 3'd3;
        else if (is_jal)                    dec_type = 3'd4;
    end

    // ALU selects are shared by EXEC and MEM so the address stays stable
    // while the data access is outstanding.
    logic [1:0] exe_src_a;
    logic       exe_src_b;
    logic [1:0] exe_op;

    always_comb begin
        exe_src_b = !(is_op || is_branch);
        exe_src_a = 2'd0;
        if (is_auipc || is_jal) exe_src_a = 2'd1;
        else if (is_lui)        exe_src_a = 2'd2;
        exe_op = 2'd0;
        if (is_op || is_opimm) exe_op = 2'd1;
        else if (is_branch)    exe_op = 2'd2;
    end

    // The counter holds the number of wait cycles already spent, so the
    // current wait cycle is number cnt_q+1. The error fires on the
    // MEM_TIMEOUT-th consecutive wait cycle.
    logic [TO_W-1:0] cnt_inc;
    logic            timeout_hit;
    assign cnt_inc     = cnt_q + 1'b1;
    assign timeout_hit = (cnt_inc == TIMEOUT_VAL);

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    logic       fetch_req_c, ir_we_c, alu_src_b_c, dmem_req_c, dmem_we_c;
    logic       rf_we_c, pc_we_c, illegal_c, bus_err_c;
    logic [2:0] instr_type_c;
    logic [1:0] alu_src_a_c, alu_op_c, wb_sel_c, pc_src_c;

    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        cnt_d        = '0;          // any state change or handshake clears it
        fetch_req_c  = 1'b0;
        ir_we_c      = 1'b0;
        instr_type_c = 3'd7;
        alu_src_a_c  = 2'd0;
        alu_src_b_c  = 1'b0;
        alu_op_c     = 2'd0;
        dmem_req_c   = 1'b0;
        dmem_we_c    = 1'b0;
        rf_we_c      = 1'b0;
        wb_sel_c     = 2'd0;
        pc_we_c      = 1'b0;
        pc_src_c     = 2'd0;
        illegal_c    = 1'b0;
        bus_err_c    = 1'b0;

        case (state_q)
            S_FETCH: begin
                fetch_req_c = 1'b1;
                if (imem_valid) begin
                    ir_we_c  = 1'b1;
                    opcode_d = instr[6:0];
                    state_d  = S_DECODE;
                end else if (timeout_hit) begin
                    bus_err_c = 1'b1;   // retry the fetch from a fresh count
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            S_DECODE: begin
                instr_type_c = dec_type;
                if (dec_legal) begin
                    state_d = S_EXEC;
                end else begin
                    illegal_c = 1'b1;
                    state_d   = S_TRAP;
                end
            end

            S_EXEC: begin
                instr_type_c = dec_type;
                alu_src_a_c  = exe_src_a;
                alu_src_b_c  = exe_src_b;
                alu_op_c     = exe_op;
                if (is_branch) begin
                    pc_we_c  = 1'b1;
                    pc_src_c = branch_taken ? 2'd1 : 2'd0;
                    state_d  = S_FETCH;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end

            S_MEM: begin
                instr_type_c = dec_type;
                alu_src_a_c  = exe_src_a;
                alu_src_b_c  = exe_src_b;
                alu_op_c     = exe_op;
                dmem_req_c   = 1'b1;
                dmem_we_c    = is_store;
                if (dmem_ready) begin
                    if (is_load) begin
                        state_d = S_WB;
                    end else begin
                        pc_we_c = 1'b1;     // store retires here, pc+4
                        state_d = S_FETCH;
                    end
                end else if (timeout_hit) begin
                    bus_err_c = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            S_WB: begin
                instr_type_c = dec_type;
                rf_we_c      = 1'b1;
                pc_we_c      = 1'b1;
                if (is_load) begin
                    wb_sel_c = 2'd1;
                end else if (is_jal || is_jalr) begin
                    wb_sel_c = 2'd2;
                    pc_src_c = 2'd1;
                end
                state_d = S_FETCH;
            end

            S_TRAP: begin
                pc_we_c  = 1'b1;
                pc_src_c = 2'd2;
                state_d  = S_FETCH;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            opcode_q <= 7'd0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            cnt_q    <= cnt_d;
        end
    end

    // While rst is high every request and enable is forced idle. This holds
    // even in the cycle where reset lands on an outstanding data access.
    assign fetch_req  = rst ? 1'b0 : fetch_req_c;
    assign ir_we      = rst ? 1'b0 : ir_we_c;
    assign instr_type = rst ? 3'd7 : instr_type_c;
    assign alu_src_a  = rst ? 2'd0 : alu_src_a_c;
    assign alu_src_b  = rst ? 1'b0 : alu_src_b_c;
    assign alu_op     = rst ? 2'd0 : alu_op_c;
    assign dmem_req   = rst ? 1'b0 : dmem_req_c;
    assign dmem_we    = rst ? 1'b0 : dmem_we_c;
    assign rf_we      = rst ? 1'b0 : rf_we_c;
    assign wb_sel     = rst ? 2'd0 : wb_sel_c;
    assign pc_we      = rst ? 1'b0 : pc_we_c;
    assign pc_src     = rst ? 2'd0 : pc_src_c;
    assign illegal    = rst ? 1'b0 : illegal_c;
    assign bus_err    = rst ? 1'b0 : bus_err_c;
    assign state      = state_q;

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_core_ctrl_fsm
//   Directed testbench for core_ctrl_fsm. Each stimulus cycle pushes a
//   hand-computed expected output vector into a scoreboard queue. A separate
//   monitor pops one entry on every falling edge and compares it against the
//   DUT outputs.
//   Vector layout: {state, fetch_req, ir_we, instr_type, alu_src_a, alu_src_b,
//                   alu_op, dmem_req, dmem_we, rf_we, wb_sel, pc_we, pc_src,
//                   illegal, bus_err}
// -----------------------------------------------------------------------------
module tb_core_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        imem_valid, dmem_ready, branch_taken;
    logic        fetch_req, ir_we, alu_src_b, dmem_req, dmem_we, rf_we, pc_we;
    logic        illegal, bus_err;
    logic [2:0]  instr_type, state;
    logic [1:0]  alu_src_a, alu_op, wb_sel, pc_src;

    core_ctrl_fsm #(.TO_W(4), .MEM_TIMEOUT(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr        (instr),
        .imem_valid   (imem_valid),
        .dmem_ready   (dmem_ready),
        .branch_taken (branch_taken),
        .fetch_req    (fetch_req),
        .ir_we        (ir_we),
        .instr_type   (instr_type),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .illegal      (illegal),
        .bus_err      (bus_err),
        .state        (state)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_LW   = 32'h0000A103;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;
    localparam logic [31:0] I_SW   = 32'h0020A023;
    localparam logic [31:0] I_JAL  = 32'h008000EF;
    localparam logic [31:0] I_LUI  = 32'h123450B7;
    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [22:0] M_ALL   = 23'h7FFFFF;
    localparam logic [22:0] M_STATE = 23'h700000;

    typedef struct {
        string       nm;
        logic [22:0] v;
        logic [22:0] m;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad   = 0;
    logic [22:0] act;

    assign act = {state, fetch_req, ir_we, instr_type, alu_src_a, alu_src_b,
                  alu_op, dmem_req, dmem_we, rf_we, wb_sel, pc_we, pc_src,
                  illegal, bus_err};

    // Argument order: st fr ir it sa sb op dq dw rw ws pw ps il be
    function automatic logic [22:0] ex(input int st, input int fr, input int ir,
                                       input int it, input int sa, input int sb,
                                       input int op, input int dq, input int dw,
                                       input int rw, input int ws, input int pw,
                                       input int ps, input int il, input int be);
        return {3'(st), 1'(fr), 1'(ir), 3'(it), 2'(sa), 1'(sb), 2'(op),
                1'(dq), 1'(dw), 1'(rw), 2'(ws), 1'(pw), 2'(ps), 1'(il), 1'(be)};
    endfunction

    // One clock cycle: record what the DUT must show during this cycle,
    // then advance to just after the next rising edge.
    task automatic cyc_m(input string nm, input logic [22:0] e, input logic [22:0] m);
        exp_t x;
        x.nm = nm;
        x.v  = e;
        x.m  = m;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string nm, input logic [22:0] e);
        cyc_m(nm, e, M_ALL);
    endtask

    task automatic txn(input string nm, input logic [31:0] w);
        $display("txn %-12s instr=%08h t=%0t", nm, w, $time);
    endtask

    // Monitor: one scoreboard entry per cycle, compared on the falling edge.
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            total++;
            if ((act & mon_e.m) !== (mon_e.v & mon_e.m)) begin
                bad++;
                $display("FAIL %s: got=%06h want=%06h (mask %06h)",
                         mon_e.nm, act, mon_e.v, mon_e.m);
            end
        end
    end

    initial begin
        rst = 1'b1; instr = 32'd0; imem_valid = 1'b0;
        dmem_ready = 1'b0; branch_taken = 1'b0;
        @(posedge clk);
        #1;

        // 1: reset, then ADDI (I-type, ALU path, 4 cycles)
        txn("reset", 32'd0);
        cyc("rst_a", ex(0,0,0,7,0,0,0,0,0,0,0,0,0,0,0));
        cyc("rst_b", ex(0,0,0,7,0,0,0,0,0,0,0,0,0,0,0));
        rst = 1'b0; imem_valid = 1'b1; instr = I_ADDI;
        txn("addi", I_ADDI);
        cyc("addi_F", ex(0,1,1,7,0,0,0,0,0,0,0,0,0,0,0));
        imem_valid = 1'b0;
        cyc("addi_D", ex(1,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        cyc("addi_E", ex(2,0,0,0,0,1,1,0,0,0,0,0,0,0,0));
        cyc("addi_W", ex(4,0,0,0,0,0,0,0,0,1,0,1,0,0,0));

        // 2: LOAD with three wait cycles
        imem_valid = 1'b1; instr = I_LW;
        txn("lw_wait3", I_LW);
        cyc("lw_F", ex(0,1,1,7,0,0,0,0,0,0,0,0,0,0,0));
        imem_valid = 1'b0;
        cyc("lw_D", ex(1,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        cyc("lw_E", ex(2,0,0,0,0,1,0,0,0,0,0,0,0,0,0));
        for (int i = 0; i < 3; i++)
            cyc("lw_M_wait", ex(3,0,0,0,0,1,0,1,0,0,0,0,0,0,0));
        dmem_ready = 1'b1;
        cyc("lw_M_rdy", ex(3,0,0,0,0,1,0,1,0,0,0,0,0,0,0));
        dmem_ready = 1'b0;
        cyc("lw_W", ex(4,0,0,0,0,0,0,0,0,1,1,1,0,0,0));

        // 3: BEQ taken, then not taken (3 cycles each, no rf_we)
        imem_valid = 1'b1; instr = I_BEQ;
        txn("beq_taken", I_BEQ);
        cyc("beq1_F", ex(0,1,1,7,0,0,0,0,0,0,0,0,0,0,0));
        imem_valid = 1'b0;
        cyc("beq1_D", ex(1,0,0,2,0,0,0,0,0,0,0,0,0,0,0));
        branch_taken = 1'b1;
        cyc("beq1_E", ex(2,0,0,2,0,0,2,0,0,0,0,1,1,0,0));
        branch_taken = 1'b0; imem_valid = 1'b1;
        txn("beq_nottkn", I_BEQ);
        cyc("beq0_F", ex(0,1,1,7,0,0,0,0,0,0,0,0,0,0,0));
        imem_valid = 1'b0;
        cyc("beq0_D", ex(1,0,0,2,0,0,0,0,0,0,0,0,0,0,0));
        cyc("beq0_E", ex(2,0,0,2,0,0,2,0,0,0,0,1,0,0,0));

        // JAL, LUI, OP: remaining select combinations
        imem_valid = 1'b1; instr = I_JAL;
        txn("jal", I_JAL);
        cyc("jal_F", ex(0,1,1,7,0,0,0,0,0,0,0,0,0,0,0));
        imem_valid = 1'b0;
        cyc("jal_D", ex(1,0,0,4,0,0,0,0,0,0,0,0,0,0,0));
        cyc("jal_E", ex(2,0,0,4,1,1,0,0,0,0,0,0,0,0,0));
        cyc("jal_W", ex(4,0,0,4,0,0,0,0,0,1,2,1,1,0,0));
        imem_valid = 1'b1; instr = I_LUI;
        txn("lui", I_LUI);
        cyc("lui_F", ex(0,1,1,7,0,0,0,0,0,0,0,0,0,0,0));
        imem_valid = 1'b0;
        cyc("lui_D", ex(1,0,0,3,0,0,0,0,0,0,0,0,0,0,0));
        cyc("lui_E", ex(2,0,0,3,2,1,0,0,0,0,0,0,0,0,0));
        cyc("lui_W", ex(4,0,0,3,0,0,0,0,0,1,0,1,0,0,0));
        imem_valid = 1'b1; instr = I_ADD;
        txn("add", I_ADD);
        cyc("add_F", ex(0,1,1,7,0,0,0,0,0,0,0,0,0,0,0));
        imem_valid = 1'b0;
        cyc("add_D", ex(1,0,0,7,0,0,0,0,0,0,0,0,0,0,0));
        cyc("add_E", ex(2,0,0,7,0,0,1,0,0,0,0,0,0,0,0));
        cyc("add_W", ex(4,0,0,7,0,0,0,0,0,1,0,1,0,0,0));

        // 4: illegal opcode -> TRAP
        imem_valid = 1'b1; instr = I_BAD;
        txn("illegal", I_BAD);
        cyc("bad_F", ex(0,1,1,7,0,0,0,0,0,0,0,0,0,0,0));
        imem_valid = 1'b0;
        cyc("bad_D", ex(1,0,0,7,0,0,0,0,0,0,0,0,0,1,0));
        cyc("bad_T", ex(5,0,0,7,0,0,0,0,0,0,0,1,2,0,0));

        // 5a: fetch timeout on the 15th wait cycle, then retry
        txn("fetch_to", 32'd0);
        for (int i = 1; i <= 14; i++)
            cyc("fto_wait", ex(0,1,0,7,0,0,0,0,0,0,0,0,0,0,0));
        cyc("fto_err", ex(0,1,0,7,0,0,0,0,0,0,0,0,0,0,1));
        cyc("fto_retry", ex(0,1,0,7,0,0,0,0,0,0,0,0,0,0,0));

        // Zero-wait STORE (4 cycles, retires from MEM)
        imem_valid = 1'b1; instr = I_SW;
        txn("sw", I_SW);
        cyc("sw_F", ex(0,1,1,7,0,0,0,0,0,0,0,0,0,0,0));
        imem_valid = 1'b0;
        cyc("sw_D", ex(1,0,0,1,0,0,0,0,0,0,0,0,0,0,0));
        cyc("sw_E", ex(2,0,0,1,0,1,0,0,0,0,0,0,0,0,0));
        dmem_ready = 1'b1;
        cyc("sw_M", ex(3,0,0,1,0,1,0,1,1,0,0,1,0,0,0));
        dmem_ready = 1'b0;

        // 5b: STORE data timeout -> bus_err, TRAP
        imem_valid = 1'b1;
        txn("sw_timeout", I_SW);
        cyc("swto_F", ex(0,1,1,7,0,0,0,0,0,0,0,0,0,0,0));
        imem_valid = 1'b0;
        cyc("swto_D", ex(1,0,0,1,0,0,0,0,0,0,0,0,0,0,0));
        cyc("swto_E", ex(2,0,0,1,0,1,0,0,0,0,0,0,0,0,0));
        for (int i = 1; i <= 14; i++)
            cyc("swto_M", ex(3,0,0,1,0,1,0,1,1,0,0,0,0,0,0));
        cyc("swto_err", ex(3,0,0,1,0,1,0,1,1,0,0,0,0,0,1));
        cyc("swto_T", ex(5,0,0,7,0,0,0,0,0,0,0,1,2,0,0));

        // 6: reset while a LOAD waits in MEM
        imem_valid = 1'b1; instr = I_LW;
        txn("lw_rst", I_LW);
        cyc("lwr_F", ex(0,1,1,7,0,0,0,0,0,0,0,0,0,0,0));
        imem_valid = 1'b0;
        cyc("lwr_D", ex(1,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        cyc("lwr_E", ex(2,0,0,0,0,1,0,0,0,0,0,0,0,0,0));
        rst = 1'b1;
        cyc_m("lwr_in_mem", ex(3,0,0,0,0,0,0,0,0,0,0,0,0,0,0), M_STATE);
        cyc("lwr_rst", ex(0,0,0,7,0,0,0,0,0,0,0,0,0,0,0));
        rst = 1'b0;
        cyc("lwr_after", ex(0,1,0,7,0,0,0,0,0,0,0,0,0,0,0));

        // Drain the scoreboard; a leftover entry counts as a miss.
        for (int i = 0; i < 5 && sb_q.size() != 0; i++)
            @(negedge clk);
        #1;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got=%0d pending entries want=0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
